// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path.
// lzb_eligible() is only referenced when DIGIT_SCAN_LZB_EN is defined.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StDrive
    } scan_state_e;

    // Digit k (k > 0) may light only if some nibble from k upward is non-zero.
    function automatic logic [NUM_DIGITS-1:0] lzb_eligible(input logic [15:0] v);
        logic [NUM_DIGITS-1:0] elig;
        elig[0] = 1'b1;
        elig[1] = (v[15:4] != 12'h000);
        elig[2] = (v[15:8] != 8'h00);
        elig[3] = (v[15:12] != 4'h0);
        return elig;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Producer-facing bus of the digit scan controller: value/enable controls
// in, registered digit select, anodes, nibble and frame pulse out.
interface digit_scan_ctrl_if;
    logic        enable;
    logic [15:0] value;
    logic        value_load;
    logic [3:0]  digit_en;
    logic [3:0]  sel;
    logic [3:0]  an;
    logic [3:0]  nibble;
    logic        frame_done;

    modport master (
        output enable, value, value_load, digit_en,
        input  sel, an, nibble, frame_done
    );

    modport slave (
        input  enable, value, value_load, digit_en,
        output sel, an, nibble, frame_done
    );
endinterface

// File: rtl/digit_scan_ctrl_selector.sv
// Existing nibble mux: picks the nibble of N addressed by one-hot sel.
module Selector (
    input  logic [15:0] N,
    input  logic [3:0]  sel,
    output logic [3:0]  H
);
    always_comb begin
        H = 4'h0;
        unique case (sel)
            4'b0001: H = N[3:0];
            4'b0010: H = N[7:4];
            4'b0100: H = N[11:8];
            4'b1000: H = N[15:12];
            default: H = 4'h0;
        endcase
    end
endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit seven-segment scan controller with dead time and frame-aligned
// value updates. Define DIGIT_SCAN_LZB_EN to enable leading-zero blanking.
module digit_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input logic              clk,
    input logic              rst_n,
    digit_scan_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] SlotLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d, an_q, an_d, lit;
    logic frame_done_q, frame_end;
    logic [15:0] pending_q, shadow_q;
    logic pend_vld_q;
    logic [3:0] nibble;

    assign frame_end = bus.enable && (state_q == StDrive) && (slot_cnt_q == SlotLast)
                       && (idx_q == 2'd3);

`ifdef DIGIT_SCAN_LZB_EN
    assign lit = bus.digit_en & lzb_eligible(shadow_q);
`else
    assign lit = bus.digit_en;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            slot_cnt_q <= '0;
            idx_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        idx_d      = idx_q;
        if (!bus.enable) begin
            state_d    = StIdle;
            slot_cnt_d = '0;
            idx_d      = 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StBlank;
                    slot_cnt_d = '0;
                    idx_d      = 2'd0;
                end
                StBlank: begin
                    slot_cnt_d = slot_cnt_q + CntW'(1);
                    if (slot_cnt_q == BlankLast) state_d = StDrive;
                end
                StDrive: begin
                    if (slot_cnt_q == SlotLast) begin
                        state_d    = StBlank;
                        slot_cnt_d = '0;
                        idx_d      = idx_q + 2'd1;
                    end else begin
                        slot_cnt_d = slot_cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d    = StIdle;
                    slot_cnt_d = '0;
                    idx_d      = 2'd0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so the registers line up with it.
    always_comb begin
        an_d = AN_OFF;
        if (state_d == StDrive && lit[idx_d]) an_d[idx_d] = 1'b0;
        sel_d = 4'b0001 << idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= 4'b0001;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            an_q         <= an_d;
            frame_done_q <= frame_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 16'h0000;
            pend_vld_q <= 1'b0;
            shadow_q   <= 16'h0000;
        end else if (state_q == StIdle) begin
            if (bus.value_load) shadow_q <= bus.value;
        end else if (frame_end) begin
            // A load landing on the frame-end cycle bypasses pending.
            if (bus.value_load) shadow_q <= bus.value;
            else if (pend_vld_q) shadow_q <= pending_q;
            pend_vld_q <= 1'b0;
        end else if (bus.value_load) begin
            pending_q  <= bus.value;
            pend_vld_q <= 1'b1;
        end
    end

    Selector u_selector (
        .N  (shadow_q),
        .sel(sel_q),
        .H  (nibble)
    );

    assign bus.sel        = sel_q;
    assign bus.an         = an_q;
    assign bus.nibble     = nibble;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2.
// Position k counts cycles since the scan started (k=0 is digit 0 BLANK).
module tb_digit_scan_ctrl;
    localparam int SD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_scan_ctrl_if bus ();

    digit_scan_ctrl #(
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;
    int k = 0;
    logic [15:0] exp_sh = 16'h0000;
    logic [3:0] en_m = 4'hF;
    logic [12:0] got, want;

    // Expected {sel, an, nibble, frame_done} at scan position pos.
    function automatic logic [12:0] model(input int pos, input logic [15:0] sh,
                                          input logic [3:0] en);
        int idx;
        int slot;
        logic [3:0] s, a, n, lit;
        logic fd;
        idx = (pos / SD) % 4;
        slot = pos % SD;
        s = 4'b0001 << idx;
        lit = en;
`ifdef DIGIT_SCAN_LZB_EN
        lit[1] = lit[1] & (sh[15:4] != 12'h000);
        lit[2] = lit[2] & (sh[15:8] != 8'h00);
        lit[3] = lit[3] & (sh[15:12] != 4'h0);
`endif
        a = (slot >= BC && lit[idx]) ? ~s : 4'hF;
        n = 4'(sh >> (4 * idx));
        fd = (pos > 0) && (pos % (4 * SD) == 0);
        return {s, a, n, fd};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        bus.enable = 1'b0;
        bus.value = 16'h0000;
        bus.value_load = 1'b0;
        bus.digit_en = 4'hF;
        #12;
        got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
        checks++;
        if (got !== {4'b0001, 4'hF, 4'h0, 1'b0})
            $display("FAIL reset got %b want %b", got, {4'b0001, 4'hF, 4'h0, 1'b0});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
        checks++;
        if (got !== {4'b0001, 4'hF, 4'h0, 1'b0})
            $display("FAIL idle got %b want %b", got, {4'b0001, 4'hF, 4'h0, 1'b0});
        else passed++;
        bus.value = 16'h1234;
        bus.value_load = 1'b1;
        step();
        bus.value_load = 1'b0;
        exp_sh = 16'h1234;
        repeat (2) begin
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            checks++;
            if (got !== {4'b0001, 4'hF, 4'h4, 1'b0})
                $display("FAIL idle_load got %b want %b", got, {4'b0001, 4'hF, 4'h4, 1'b0});
            else passed++;
            step();
        end
    endtask

    task automatic test_scan();
        bus.enable = 1'b1;
        k = -1;
        while (k < 32) begin
            step();
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL scan k=%0d got %b want %b", k, got, want);
            else passed++;
        end
    endtask

    task automatic test_load_midframe();
        while (k < 44) begin
            step();
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL pre_load k=%0d got %b want %b", k, got, want);
            else passed++;
        end
        bus.value = 16'hABCD;
        bus.value_load = 1'b1;
        step();
        bus.value_load = 1'b0;
        while (k < 95) begin
            if (k == 64) exp_sh = 16'hABCD;
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL mid_load k=%0d got %b want %b", k, got, want);
            else passed++;
            step();
        end
    endtask

    task automatic test_load_frame_end();
        bus.value = 16'h5A3C;
        bus.value_load = 1'b1;
        step();
        bus.value_load = 1'b0;
        exp_sh = 16'h5A3C;
        while (k < 128) begin
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL end_load k=%0d got %b want %b", k, got, want);
            else passed++;
            step();
        end
    endtask

    task automatic test_digit_mask();
        en_m = 4'b0101;
        bus.digit_en = 4'b0101;
        while (k < 160) begin
            step();
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL mask k=%0d got %b want %b", k, got, want);
            else passed++;
        end
        en_m = 4'hF;
        bus.digit_en = 4'hF;
    endtask

    task automatic test_enable_drop();
        while (k < 180) step();
        bus.enable = 1'b0;
        repeat (4) begin
            step();
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            checks++;
            if (got !== {4'b0001, 4'hF, exp_sh[3:0], 1'b0})
                $display("FAIL en_drop got %b want %b", got,
                         {4'b0001, 4'hF, exp_sh[3:0], 1'b0});
            else passed++;
        end
        bus.enable = 1'b1;
        k = -1;
        while (k < 11) begin
            step();
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL re_enable k=%0d got %b want %b", k, got, want);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_drive();
        while (k < 13) step();
        #2 rst_n = 1'b0;
        #1;
        exp_sh = 16'h0000;
        got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
        checks++;
        if (got !== {4'b0001, 4'hF, 4'h0, 1'b0})
            $display("FAIL async_reset got %b want %b", got, {4'b0001, 4'hF, 4'h0, 1'b0});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        k = -1;
        while (k < 9) begin
            step();
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL post_reset k=%0d got %b want %b", k, got, want);
            else passed++;
        end
    endtask

`ifdef DIGIT_SCAN_LZB_EN
    task automatic test_lzb();
        while (k < 31) step();
        bus.value = 16'h0050;
        bus.value_load = 1'b1;
        step();
        bus.value_load = 1'b0;
        exp_sh = 16'h0050;
        while (k < 63) begin
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL lzb_0050 k=%0d got %b want %b", k, got, want);
            else passed++;
            step();
        end
        bus.value = 16'h0000;
        bus.value_load = 1'b1;
        step();
        bus.value_load = 1'b0;
        exp_sh = 16'h0000;
        while (k < 96) begin
            got = {bus.sel, bus.an, bus.nibble, bus.frame_done};
            want = model(k, exp_sh, en_m);
            checks++;
            if (got !== want) $display("FAIL lzb_zero k=%0d got %b want %b", k, got, want);
            else passed++;
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_load_frame_end();
        test_digit_mask();
        test_enable_drop();
        test_reset_mid_drive();
`ifdef DIGIT_SCAN_LZB_EN
        test_lzb();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexing controller for the four-digit seven-segment display. Holds a double-buffered 16-bit display value, rotates a one-hot digit select through digits 0..3 at a programmable slot rate, and drives the existing `Selector` nibble mux so the segment decoder always sees the nibble of the digit being lit. Sits between game/score logic (value producer) and the segment decoder/anode pins. It inserts dead time between digits to prevent ghosting and applies new values only at frame boundaries to prevent tearing.

## Interface

- `SCAN_DIV`, 100000 — clock cycles per digit slot (1 ms at 100 MHz); legal ≥ 2.
- `BLANK_CYCLES`, 1000 — dead-time cycles at the start of each slot, anodes off; legal 1..SCAN_DIV-1.
- `clk` in 1 — system clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `enable` in 1 — scan enable; low forces display dark.
- `value` in 16 — display value, digit k = `value[4k+3:4k]`.
- `value_load` in 1 — one-cycle strobe; capture `value` as pending.
- `digit_en` in 4 — per-digit lit mask (bit k = digit k).
- `sel` out 4 — registered one-hot digit select to `Selector`.
- `an` out 4 — registered active-low anodes.
- `nibble` out 4 — `Selector` output for the current digit, from the shadow value.
- `frame_done` out 1 — one-cycle pulse at each frame boundary.

## Operation

- Registers: `slot_cnt` (0..SCAN_DIV-1), `idx` (0..3), `pending`, `pend_vld`, `shadow`, state.
- States: IDLE, BLANK, DRIVE.
  - IDLE: `an=4'b1111`, `slot_cnt=0`, `idx=0`. Exit to BLANK on `enable=1`.
  - BLANK: `an=4'b1111` while `slot_cnt < BLANK_CYCLES`. Then go to DRIVE.
  - DRIVE: `an[idx]=0` if `digit_en[idx]` (all others 1) until `slot_cnt=SCAN_DIV-1`. Then `idx` increments (3 wraps to 0), `slot_cnt` returns to 0, and the state goes to BLANK.
- `sel` is always `1<<idx`. It changes only on slot rollover, i.e. entering BLANK, so `nibble` is stable throughout DRIVE.
- `digit_en` is sampled each cycle. A masked digit keeps full slot timing with its anode held off.
- Value buffering:
  - `value_load` sets `pending<=value`, `pend_vld<=1`. A later load overwrites `pending`.
  - At frame end (last DRIVE cycle of idx 3): if `pend_vld`, then `shadow<=pending` and `pend_vld` clears.
  - A `value_load` in that same cycle goes straight to `shadow`.
  - In IDLE, a load updates `shadow` directly.
- `frame_done` fires in the first cycle of idx 0 BLANK following idx 3. It never fires for the first slot after leaving IDLE.
- `enable` low in any state: next cycle is IDLE, `an=4'b1111`, `idx=0`, `sel=4'b0001`. `pend_vld` is retained.
- Reset values: state IDLE, `sel=4'b0001`, `an=4'b1111`, `frame_done=0`, `shadow=0`, `pending=0`, `pend_vld=0`, `slot_cnt=0`. `nibble=shadow[3:0]=0`.
- Reset assertion mid-frame returns all of these immediately (asynchronously).

## Timing

- `enable` rising at cycle t: BLANK from t+1, first anode low at t+1+BLANK_CYCLES.
- Slot = SCAN_DIV cycles; frame = 4·SCAN_DIV cycles; duty per digit = (SCAN_DIV−BLANK_CYCLES)/(4·SCAN_DIV).
- `value_load` to first lit digit showing the new value: at most one frame plus BLANK_CYCLES.
- `an` and `sel` are registered outputs. `nibble` is combinational from registered `sel`/`shadow` only.

## Configuration

- `DIGIT_SCAN_LZB_EN` defined: leading-zero blanking.
  - Digit k's anode is suppressed when all shadow nibbles k..3 are zero and k > 0.
  - Digit 0 is always eligible.
  - The suppression is ANDed with `digit_en`; slot timing is unchanged.
- `DIGIT_SCAN_LZB_EN` undefined: every digit enabled by `digit_en` is lit, including leading zeros.

## Structure

- Shared package `display_pkg`: state enum (IDLE/BLANK/DRIVE), `NUM_DIGITS=4`, `AN_OFF=4'b1111`.
- One sub-module: the existing `Selector` (`N=shadow`, `sel=sel`, `H=nibble`), instantiated unchanged.
- Counters and FSM stay in this module.

## Test plan

All scenarios use `SCAN_DIV=8`, `BLANK_CYCLES=2`.

- Reset, then `enable=1`, `digit_en=4'hF`, `shadow=16'h1234`:
  - `sel` walks 0001→0010→0100→1000 every 8 cycles.
  - `an` is 1111 for 2 cycles, then 1110 / 1101 / 1011 / 0111 for 6.
  - `nibble` is 4, 3, 2, 1.
  - `frame_done` pulses every 32 cycles.
- `value_load` with `16'hABCD` mid-frame (digit 1 DRIVE): display keeps the old value through digit 3; next frame shows D, C, B, A. `frame_done` coincides with the change.
- `value_load` on the exact frame-end cycle: the new value appears in the very next frame.
- `digit_en=4'b0101`: `an[1]` and `an[3]` stay 1 for the whole frame; frame remains 32 cycles.
- `enable` dropped during digit 2, and separately `rst_n` asserted mid-DRIVE: `an=1111`, `sel=0001` (immediately for reset). Re-enable restarts at digit 0 BLANK.
- With `DIGIT_SCAN_LZB_EN`, `shadow=16'h0050`: digits 2–3 dark, digits 0–1 lit. With `shadow=0`, only digit 0 is lit, showing 0.
